// File: rtl/f_sort4.sv
// ============================================================================
// Module   : f_sort4
// Brief    : Burst float sorter, one compare-and-swap per cycle (bubble sort).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f_sort4 #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int          IW     = (N <= 2) ? 1 : $clog2(N);
  localparam logic [IW-1:0] C_LAST  = IW'(N - 1);
  localparam logic [IW-1:0] C_LASTJ = IW'(N - 2);
  localparam logic [IW-1:0] C_ONE   = IW'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [N];
  logic [31:0]     mem_d [N];
  logic [IW-1:0]   wr_q, wr_d, rd_q, rd_d, j_q, j_d, pass_q, pass_d;
  logic            swapped_q, swapped_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            w_swap;
  logic [IW-1:0]   w_j1;

  // Sign-magnitude float mapped onto an unsigned total order.
  function automatic logic [31:0] f_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  assign w_j1 = j_q + C_ONE;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    j_d       = j_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    w_swap    = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[wr_q] = in_data;
          if (wr_q == C_LAST) begin
            wr_d      = '0;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            state_d   = S_SORT;
          end else begin
            wr_d = wr_q + C_ONE;
          end
        end
      end
      S_SORT: begin
        w_swap = f_key(mem_q[j_q]) > f_key(mem_q[w_j1]);
        if (w_swap) begin
          mem_d[j_q]  = mem_q[w_j1];
          mem_d[w_j1] = mem_q[j_q];
        end
        if (j_q == C_LASTJ) begin
          if (!(swapped_q || w_swap) || (pass_q == C_LASTJ)) begin
            state_d = S_DRAIN;
            rd_d    = '0;
          end else begin
            j_d       = '0;
            pass_d    = pass_q + C_ONE;
            swapped_d = 1'b0;
          end
        end else begin
          j_d       = w_j1;
          swapped_d = swapped_q | w_swap;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_q == C_LAST) begin
            rd_d    = '0;
            state_d = S_LOAD;
          end else begin
            rd_d = rd_q + C_ONE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Outputs are decoded from the next state so they are pure registers.
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d != S_LOAD);
    out_data_d  = out_valid_d ? mem_d[rd_d] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      for (int i = 0; i < N; i++) mem_q[i] <= 32'h0;
      wr_q        <= '0;
      rd_q        <= '0;
      j_q         <= '0;
      pass_q      <= '0;
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      j_q         <= j_d;
      pass_q      <= pass_d;
      swapped_q   <= swapped_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_f_sort4.sv
// ============================================================================
// Module   : tb_f_sort4
// Brief    : Randomised and directed self-checking bench for f_sort4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f_sort4;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [N];
  int          exp_lat;

  f_sort4 #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Reference: stable insertion sort; bubble pass count from max left-inversions.
  task automatic model(input logic [31:0] w [N]);
    logic [31:0] s [N];
    logic [31:0] v;
    int k, c, mx, passes;
    s = w;
    for (int i = 1; i < N; i++) begin
      v = s[i];
      k = i;
      while (k > 0 && key(s[k-1]) > key(v)) begin
        s[k] = s[k-1];
        k--;
      end
      s[k] = v;
    end
    exp_q = s;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      c = 0;
      for (int j = 0; j < i; j++) if (key(w[j]) > key(w[i])) c++;
      if (c > mx) mx = c;
    end
    passes  = (mx + 1 > N - 1) ? N - 1 : mx + 1;
    exp_lat = passes * (N - 1);
  endtask

  task automatic load(input logic [31:0] w [N], input bit hold_valid);
    for (int i = 0; i < N; i++) begin
      check("load_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = w[i];
      @(posedge clk); #1;
    end
    in_valid = hold_valid;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      check("sort_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic drain(input logic [7:0] pat, input int pat_len);
    int idx, cyc;
    bit r;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 200) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check($sformatf("data[%0d]", idx), out_data, exp_q[idx]);
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
      r = (cyc < pat_len) ? pat[cyc] : 1'($urandom_range(0, 1));
      out_ready = r;
      @(posedge clk); #1;
      if (r) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_count", 32'(idx), 32'(N));
    check("turn_in_ready", 32'(in_ready), 32'd1);
    check("turn_out_valid", 32'(out_valid), 32'd0);
    check("turn_busy", 32'(busy), 32'd0);
  endtask

  task automatic burst(input logic [31:0] w [N], input bit hold_valid,
                       input logic [7:0] pat, input int pat_len);
    model(w);
    load(w, hold_valid);
    wait_valid();
    drain(pat, pat_len);
  endtask

  logic [31:0] w_sorted [N] = '{32'hBF80_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000};
  logic [31:0] w_rev    [N] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000, 32'hBF80_0000};
  logic [31:0] w_spec   [N] = '{32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000, 32'h0000_0000};
  logic [31:0] w_dup    [N] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000};
  logic [31:0] pool     [8] = '{32'h7FC0_0000, 32'hFFC0_0001, 32'h7F80_0000, 32'hFF80_0000,
                                32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};

  initial begin
    logic [31:0] w [N];
    bit seen;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", out_data, 32'h0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    burst(w_sorted, 1'b0, 8'hFF, 8);
    burst(w_rev,    1'b0, 8'hFF, 8);
    burst(w_spec,   1'b0, 8'hFF, 8);
    burst(w_rev,    1'b1, 8'b0101_1001, 7);

    // Reset during the second SORT cycle must discard the burst.
    model(w_rev);
    load(w_rev, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    burst(w_dup, 1'b0, 8'hFF, 8);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < N; i++)
        w[i] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : $urandom;
      burst(w, 1'b0, 8'h00, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/f_sort4.md
# f_sort4

Sequential floating-point sort engine that sits directly downstream of the single-precision comparator stage. It collects a burst of N IEEE-754 single-precision words over a valid/ready input port and orders them ascending with one compare-and-swap per cycle (bubble passes with early exit). It then streams the sorted words out over a valid/ready output port. It is the first consumer of the comparator's ordering decision, using the same 32-bit operand format.

## Interface
- N, default 4: words per burst; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  32  IEEE-754 single-precision word.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  downstream accepts a word this cycle.
- out_data  output  32  sorted word, smallest first.
- busy  output  1  high in SORT and DRAIN.

## Operation
- **Ordering key.** key(x) = x[31] ? ~x : (x ^ 32'h8000_0000). Words are compared as unsigned keys.
  - Resulting order: -NaN < -inf < negatives < -0 < +0 < positives < +inf < +NaN.
  - The order is a total order, so there are no unordered cases.
- **Swap rule.** Swap buf[j] and buf[j+1] only when key(buf[j]) > key(buf[j+1]), strictly. Equal words never swap, so the sort is stable.
- **LOAD state** (entered after reset):
  - in_ready=1.
  - Each in_valid&&in_ready edge writes buf[wr] and increments wr.
  - The edge that accepts word N-1 moves to SORT, clears wr, and sets j=0, pass=0, swapped=0.
- **SORT state:**
  - in_ready=0.
  - Each cycle performs one compare-swap on (buf[j], buf[j+1]) and ORs the swap into swapped.
  - j increments up to N-2.
  - At j=N-2 the pass ends:
    - If swapped (including this cycle's swap) is 0, or pass==N-2, go to DRAIN.
    - Otherwise set j=0, increment pass, and clear swapped.
- **DRAIN state:**
  - out_valid=1 and out_data=buf[rd].
  - Each out_valid&&out_ready edge increments rd.
  - The edge consuming word N-1 returns to LOAD and clears rd.
  - in_valid is ignored and in_ready stays 0.
- **Data handling.** Words are never modified; NaN payloads and the sign of zero pass through bit-exact.

## Timing
- **Reset values:**
  - in_ready=0 while rst_n is low.
  - out_valid=0, out_data=32'h0, busy=0.
  - buf, wr, rd, j, pass and swapped are all cleared.
  - The state is LOAD, so in_ready=1 in the first cycle after rst_n is sampled high.
- **Load throughput:** one word per cycle while in_valid=1.
- **Sort latency,** measured from the edge accepting the last word to the first cycle with out_valid=1:
  - Minimum N-1 cycles (input already sorted).
  - Maximum (N-1)² cycles (input in reverse order).
  - The bound is always a multiple of N-1 cycles.
  - For N=4 the latency is 3, 6 or 9 cycles.
- **Drain throughput:** one word per cycle while out_ready=1.
  - out_data stays stable while out_valid=1 and out_ready=0.
- **Turnaround:** in_ready=1 in the cycle after the last word is consumed.
  - There is no overlap between bursts.
- **Reset mid-operation:** synchronous reset in any state aborts the burst.
  - Partially loaded or partially drained words are discarded.
  - Nothing from the aborted burst is emitted afterwards.
- **Outputs are registers or registered-state decodes.** There is no combinational path from in_valid or out_ready to any output.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0. In the first cycle after release -> in_ready=1, busy=0.
- **Already sorted:** load {BF800000, 3F000000, 3F800000, 40000000} on back-to-back cycles -> out_valid rises exactly 3 cycles after the last acceptance. Output order is unchanged.
- **Reverse order:** load {40000000, 3F800000, 3F000000, BF800000} -> out_valid rises exactly 9 cycles after the last acceptance. Output is BF800000, 3F000000, 3F800000, 40000000.
- **Special values:** load {7FC00000, 80000000, FF800000, 00000000} -> output is FF800000, 80000000, 00000000, 7FC00000, bit-exact.
- **Backpressure:** during DRAIN toggle out_ready 1,0,0,1,1,0,1 while holding in_valid=1 -> each word is held stable while stalled, no word is dropped or duplicated, and in_ready stays 0 until the cycle after the 4th handshake.
- **Mid-sort reset:** load reverse data, pulse rst_n=0 for one cycle in the 2nd SORT cycle -> out_valid is never asserted for that burst. A following burst of {3F800000, 3F800000, 00000000, BF800000} sorts to BF800000, 00000000, 3F800000, 3F800000.
